// File: rtl/spi_cfg_regfile_if.sv
// rtl/spi_cfg_regfile_if.sv - captured SPI word bus between capture port and config register file
interface spi_cfg_regfile_if;
  logic [15:0] word_in;
  logic        word_valid;

  modport master (output word_in, output word_valid);
  modport slave  (input  word_in, input  word_valid);
endinterface

// File: rtl/spi_cfg_regfile.sv
// rtl/spi_cfg_regfile.sv - shadow/active filter config registers with keyed, tick-aligned atomic commit
module spi_cfg_regfile #(
  parameter logic [11:0] COMMIT_KEY = 12'hA5C,
  parameter logic [7:0]  RST_DECIM  = 8'd64,
  parameter logic [11:0] RST_GAIN   = 12'h400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_cfg_regfile_if.slave        spi,
  input  logic                    sample_tick,
  output logic [7:0]              cfg_decim,
  output logic [11:0]             cfg_pitch,
  output logic [11:0]             cfg_gain,
  output logic                    cfg_mute,
  output logic                    cfg_bypass,
  output logic                    cfg_update,
  output logic                    commit_pending,
  output logic                    err_sticky
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        apply;

  logic [7:0]  sh_decim;
  logic [11:0] sh_pitch;
  logic [11:0] sh_gain;
  logic        sh_mute;
  logic        sh_bypass;

  logic [3:0]  addr;
  logic [11:0] data;
  logic        commit_word;
  logic        err_set;
  logic        err_clr;

  assign addr = spi.word_in[15:12];
  assign data = spi.word_in[11:0];

  always_comb begin
    commit_word = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    if (spi.word_valid) begin
      case (addr)
        4'h0, 4'h1, 4'h2, 4'h3: ;
        4'hE: err_clr = 1'b1;
        4'hF: begin
          if (data == COMMIT_KEY) commit_word = 1'b1;
          else                    err_set     = 1'b1;
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    apply      = 1'b0;
    case (state)
      IDLE: begin
        // A tick coinciding with the commit word is too early; apply waits for the next one.
        if (commit_word) state_next = PENDING;
      end
      PENDING: begin
        if (sample_tick) begin
          apply      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign commit_pending = (state == PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_decim  <= RST_DECIM;
      sh_pitch  <= '0;
      sh_gain   <= RST_GAIN;
      sh_mute   <= 1'b0;
      sh_bypass <= 1'b0;
    end else if (spi.word_valid) begin
      case (addr)
        4'h0: sh_decim <= data[7:0];
        4'h1: sh_pitch <= data;
        4'h2: sh_gain  <= data;
        4'h3: begin
          sh_mute   <= data[0];
          sh_bypass <= data[1];
        end
        default: ;
      endcase
    end
  end

  // Active copy samples shadow before any same-edge shadow write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_decim  <= RST_DECIM;
      cfg_pitch  <= '0;
      cfg_gain   <= RST_GAIN;
      cfg_mute   <= 1'b0;
      cfg_bypass <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= apply;
      if (apply) begin
        cfg_decim  <= sh_decim;
        cfg_pitch  <= sh_pitch;
        cfg_gain   <= sh_gain;
        cfg_mute   <= sh_mute;
        cfg_bypass <= sh_bypass;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end else if (err_set) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// tb/tb_spi_cfg_regfile.sv - directed self-checking bench for spi_cfg_regfile
module tb_spi_cfg_regfile;
  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [7:0]  cfg_decim;
  logic [11:0] cfg_pitch;
  logic [11:0] cfg_gain;
  logic        cfg_mute;
  logic        cfg_bypass;
  logic        cfg_update;
  logic        commit_pending;
  logic        err_sticky;

  int errors = 0;
  int checks = 0;

  spi_cfg_regfile_if spi_bus ();

  spi_cfg_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi            (spi_bus),
    .sample_tick    (sample_tick),
    .cfg_decim      (cfg_decim),
    .cfg_pitch      (cfg_pitch),
    .cfg_gain       (cfg_gain),
    .cfg_mute       (cfg_mute),
    .cfg_bypass     (cfg_bypass),
    .cfg_update     (cfg_update),
    .commit_pending (commit_pending),
    .err_sticky     (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, settle 1ns past it.
  task automatic step(input logic [15:0] w, input logic v, input logic t);
    spi_bus.word_in    = w;
    spi_bus.word_valid = v;
    sample_tick        = t;
    @(posedge clk);
    #1;
    spi_bus.word_valid = 1'b0;
    sample_tick        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spi_bus.word_in = 16'h0000;
    spi_bus.word_valid = 1'b0;
    sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(16'h0, 1'b0, 1'b0);
    checks++; if (cfg_decim !== 8'd64) begin errors++; $display("FAIL reset_decim got %h want %h", cfg_decim, 8'd64); end
    checks++; if (cfg_pitch !== 12'h000) begin errors++; $display("FAIL reset_pitch got %h want %h", cfg_pitch, 12'h000); end
    checks++; if (cfg_gain !== 12'h400) begin errors++; $display("FAIL reset_gain got %h want %h", cfg_gain, 12'h400); end
    checks++; if ({cfg_mute, cfg_bypass} !== 2'b00) begin errors++; $display("FAIL reset_ctrl got %b want 00", {cfg_mute, cfg_bypass}); end
    checks++; if ({cfg_update, commit_pending, err_sticky} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {cfg_update, commit_pending, err_sticky}); end
  endtask

  task automatic test_shadow_no_commit();
    step(16'h0020, 1'b1, 1'b0);
    step(16'h1FF6, 1'b1, 1'b0);
    step(16'h2200, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(16'h0, 1'b0, 1'b1);
      checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL idle_tick_update[%0d] got %b want 0", i, cfg_update); end
    end
    checks++; if ({cfg_decim, cfg_pitch, cfg_gain} !== {8'd64, 12'h000, 12'h400}) begin errors++; $display("FAIL no_commit_active got %h want %h", {cfg_decim, cfg_pitch, cfg_gain}, {8'd64, 12'h000, 12'h400}); end
  endtask

  task automatic test_commit();
    step(16'hFA5C, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL pending_wait[%0d] got %b want 1", i, commit_pending); end
      checks++; if (cfg_decim !== 8'd64) begin errors++; $display("FAIL pending_decim_hold[%0d] got %h want %h", i, cfg_decim, 8'd64); end
      step(16'h0, 1'b0, 1'b0);
    end
    step(16'h0, 1'b0, 1'b1);
    checks++; if (cfg_decim !== 8'h20) begin errors++; $display("FAIL commit_decim got %h want %h", cfg_decim, 8'h20); end
    checks++; if (cfg_pitch !== 12'hFF6) begin errors++; $display("FAIL commit_pitch got %h want %h", cfg_pitch, 12'hFF6); end
    checks++; if (cfg_gain !== 12'h200) begin errors++; $display("FAIL commit_gain got %h want %h", cfg_gain, 12'h200); end
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL commit_update got %b want 1", cfg_update); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL commit_pending_fall got %b want 0", commit_pending); end
    step(16'h0, 1'b0, 1'b0);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL update_one_cycle got %b want 0", cfg_update); end
  endtask

  task automatic test_errors();
    step(16'hF123, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL bad_key_err got %b want 1", err_sticky); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL bad_key_pending got %b want 0", commit_pending); end
    step(16'h5000, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_stays got %b want 1", err_sticky); end
    step(16'hE000, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_sticky); end
    step(16'hD7FF, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL addr_d_err got %b want 1", err_sticky); end
    step(16'hEFFF, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clear_data got %b want 0", err_sticky); end
    step(16'h3FFC, 1'b1, 1'b0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL legal_write_no_err got %b want 0", err_sticky); end
  endtask

  task automatic test_simultaneous();
    // shadow ctrl currently 00 (0x3FFC wrote data[1:0]=00)
    step(16'hFA5C, 1'b1, 1'b0);
    step(16'h3003, 1'b1, 1'b1);
    checks++; if ({cfg_mute, cfg_bypass} !== 2'b00) begin errors++; $display("FAIL same_cycle_old_ctrl got %b want 00", {cfg_mute, cfg_bypass}); end
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL same_cycle_update got %b want 1", cfg_update); end
    step(16'hFA5C, 1'b1, 1'b0);
    step(16'h0, 1'b0, 1'b1);
    checks++; if ({cfg_mute, cfg_bypass} !== 2'b11) begin errors++; $display("FAIL second_commit_ctrl got %b want 11", {cfg_mute, cfg_bypass}); end
    step(16'hFA5C, 1'b1, 1'b1);
    checks++; if ({commit_pending, cfg_update} !== 2'b10) begin errors++; $display("FAIL idle_commit_with_tick got %b want 10", {commit_pending, cfg_update}); end
  endtask

  task automatic test_back_to_back();
    // still PENDING from previous task; a repeat commit is a no-op
    step(16'h0011, 1'b1, 1'b0);
    step(16'h1022, 1'b1, 1'b0);
    step(16'h2033, 1'b1, 1'b0);
    step(16'hFA5C, 1'b1, 1'b0);
    checks++; if ({commit_pending, err_sticky} !== 2'b10) begin errors++; $display("FAIL repeat_commit got %b want 10", {commit_pending, err_sticky}); end
    step(16'h0, 1'b0, 1'b1);
    checks++; if ({cfg_decim, cfg_pitch, cfg_gain} !== {8'h11, 12'h022, 12'h033}) begin errors++; $display("FAIL b2b_active got %h want %h", {cfg_decim, cfg_pitch, cfg_gain}, {8'h11, 12'h022, 12'h033}); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL b2b_pending got %b want 0", commit_pending); end
  endtask

  task automatic test_reset_pending();
    step(16'h0099, 1'b1, 1'b0);
    step(16'h5000, 1'b1, 1'b0);
    step(16'hFA5C, 1'b1, 1'b0);
    checks++; if ({commit_pending, err_sticky} !== 2'b11) begin errors++; $display("FAIL pre_reset_state got %b want 11", {commit_pending, err_sticky}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({cfg_decim, cfg_pitch, cfg_gain} !== {8'd64, 12'h000, 12'h400}) begin errors++; $display("FAIL async_reset_active got %h want %h", {cfg_decim, cfg_pitch, cfg_gain}, {8'd64, 12'h000, 12'h400}); end
    checks++; if ({cfg_mute, cfg_bypass, cfg_update, commit_pending, err_sticky} !== 5'b00000) begin errors++; $display("FAIL async_reset_flags got %b want 00000", {cfg_mute, cfg_bypass, cfg_update, commit_pending, err_sticky}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(16'h0, 1'b0, 1'b1);
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL post_reset_tick_update got %b want 0", cfg_update); end
    step(16'hFA5C, 1'b1, 1'b0);
    step(16'h0, 1'b0, 1'b1);
    checks++; if (cfg_decim !== 8'd64) begin errors++; $display("FAIL shadow_reset_decim got %h want %h", cfg_decim, 8'd64); end
  endtask

  initial begin
    test_reset();
    test_shadow_no_commit();
    test_commit();
    test_errors();
    test_simultaneous();
    test_back_to_back();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
